muldiv_unit: RTL
================

# muldiv_unit

Execute-stage unit that consumes the RV32M control codes produced by the ALU decoder (ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU) and returns the 32-bit result. Multiplies complete in one cycle. Divides and remainders run on a 32-iteration restoring divider. A start/busy/done handshake lets the hazard unit stall the pipeline around it. Non-M control codes stay in the main ALU and are ignored here.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- start_i  in  1  request to start an operation; sampled only when accepted (see Operation).
- flush_i  in  1  synchronous abort; drops any operation in flight.
- alu_control_i  in  `ALU_CONTROL_SIZE  operation code from the ALU decoder.
- src_a_i  in  32  rs1 operand (dividend / multiplicand).
- src_b_i  in  32  rs2 operand (divisor / multiplier).
- busy_o  out  1  divider iterating; the pipeline must stall.
- done_o  out  1  one-cycle pulse; result_o is valid.
- result_o  out  32  result; held from done_o until the next accepted operation.

## Operation
- States:
  - IDLE.
  - DIV: 32 iterations.
  - ADJ: sign fix-up.
  - DONE: 1 cycle.
- Accept: start_i=1 in IDLE or DONE, flush_i=0, and alu_control_i is an M code. Other codes are ignored: no state change, no done_o.
- Accepted MUL*: compute the 64-bit product and register the selected half.
  - MUL: low 32 bits.
  - MULH: signed×signed, high 32 bits.
  - MULHSU: signed×unsigned, high 32 bits.
  - MULHU: unsigned×unsigned, high 32 bits.
  - Next state: DONE.
- Accepted DIV/DIVU/REM/REMU with divisor 0: result is 0xFFFFFFFF (DIV/DIVU) or src_a (REM/REMU). Next state: DONE.
- Accepted DIV/REM with 0x80000000 / 0xFFFFFFFF (signed overflow): result is 0x80000000 (DIV) or 0 (REM). Next state: DONE.
- Other divides:
  - Latch the operand magnitudes (signed ops take absolute values), the op code, and the quotient/remainder sign flags.
  - Enter DIV with a 6-bit counter at 0.
  - Each DIV cycle does one restoring step on a 33-bit partial remainder.
  - After counter 31, go to ADJ.
  - ADJ negates the quotient if signs differ (DIV). It negates the remainder if the dividend was negative (REM).
  - ADJ drives result_o and moves to DONE.
- DONE: done_o=1. Next state is IDLE, or a new accepted operation.
- flush_i=1 in any state: go to IDLE, busy_o=0, no done_o. flush_i overrides start_i in the same cycle. result_o is unchanged.
- start_i while busy_o=1: ignored.
- Reset mid-operation: same as reset from any state.

## Timing
- Reset values: state IDLE, busy_o=0, done_o=0, result_o=0, counter 0.
- Start accepted at edge k:
  - MUL* and divide special cases: done_o high in cycle k+1 (latency 1).
  - Normal divide: busy_o high in cycles k+1..k+33 (DIV for 32 cycles, then ADJ); done_o in cycle k+34 (latency 34).
- busy_o is 1 only in DIV and ADJ. It is 0 in DONE, so back-to-back operations are allowed.
- result_o changes only on the edge that enters DONE.

## Structure
- The ALU_* codes and `ALU_CONTROL_SIZE stay in defines_header.svh, shared with the ALU decoder.
- Add to the shared package:
  - the muldiv state enum (IDLE, DIV, ADJ, DONE);
  - a function is_muldiv(code) → bit.
- Sub-module div_iter:
  - holds the remainder/quotient shift registers, the counter, and the step logic;
  - ports: load, dividend magnitude, divisor magnitude, step enable, quotient, remainder, last.
- The multiply path and the state machine live in muldiv_unit.

## Test plan
- MULH 0xFFFFFFFF × 0xFFFFFFFF → result 0x00000000 and done_o in cycle k+1. MULHU on the same operands → 0xFFFFFFFE. MUL on the same operands → 0x00000001.
- DIV −7 (0xFFFFFFF9) / 2 → 0xFFFFFFFD; REM on the same operands → 0xFFFFFFFF. Both: busy_o for exactly 33 cycles, then done_o in cycle k+34.
- DIVU 100/0 → 0xFFFFFFFF; REMU 100/0 → 100 (0x64). Both with latency 1. DIV 0x80000000/0xFFFFFFFF → 0x80000000, and REM on the same operands → 0.
- DIVU 1000/7 started; flush_i pulsed at cycle k+10 → IDLE, no done_o, result_o unchanged. A new start afterwards → 142 (0x8E).
- start_i during DIV with a MUL code → ignored. start_i in the DONE cycle → accepted, done_o again in the next cycle. start_i with ALU_ADD → no response.
- rst_i asserted at cycle k+5 of a divide → next cycle busy_o=0, done_o=0, result_o=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the RV32M multiply/divide unit.
`ifndef DEFINES_HEADER_SVH
`include "defines_header.svh"
`endif

package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_DIV,
    MD_ADJ,
    MD_DONE
  } muldiv_state_e;

  function automatic logic is_muldiv(input logic [`ALU_CONTROL_SIZE-1:0] code);
    case (code)
      `ALU_MUL, `ALU_MULH, `ALU_MULHSU, `ALU_MULHU,
      `ALU_DIV, `ALU_DIVU, `ALU_REM, `ALU_REMU: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/defines_header.svh
// ALU control codes shared by the ALU decoder, the main ALU and the M-extension unit.
`ifndef DEFINES_HEADER_SVH
`define DEFINES_HEADER_SVH

`define ALU_CONTROL_SIZE 5

`define ALU_ADD    5'd0
`define ALU_SUB    5'd1
`define ALU_AND    5'd2
`define ALU_OR     5'd3
`define ALU_XOR    5'd4
`define ALU_SLT    5'd5
`define ALU_SLTU   5'd6
`define ALU_SLL    5'd7
`define ALU_SRL    5'd8
`define ALU_SRA    5'd9
`define ALU_MUL    5'd10
`define ALU_MULH   5'd11
`define ALU_MULHSU 5'd12
`define ALU_MULHU  5'd13
`define ALU_DIV    5'd14
`define ALU_DIVU   5'd15
`define ALU_REM    5'd16
`define ALU_REMU   5'd17

`endif

// File: rtl/muldiv_unit_div_iter.sv
// Restoring divider datapath: one quotient bit per step, 32 steps per divide.
module div_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            step_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o,
  output logic            last_o
);

  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvs_q;
  logic [5:0]      cnt_q;

  logic [XLEN:0]   trial;
  logic [XLEN:0]   diff;

  // The dividend is shifted out of the quotient register as quotient bits shift in.
  always_comb begin
    trial = {rem_q, quo_q[XLEN-1]};
    diff  = trial - {1'b0, dvs_q};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      rem_q <= '0;
      quo_q <= dividend_i;
      dvs_q <= divisor_i;
      cnt_q <= '0;
    end else if (step_i) begin
      if (!diff[XLEN]) begin
        rem_q <= diff[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_q <= trial[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b0};
      end
      cnt_q <= cnt_q + 6'd1;
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;
  assign last_o      = (cnt_q == 6'd31);

endmodule

// File: rtl/muldiv_unit.sv
// RV32M execute unit: single-cycle multiplies, 32-step restoring divide with start/busy/done handshake.
`ifndef DEFINES_HEADER_SVH
`include "defines_header.svh"
`endif

module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic                         flush_i,
  input  logic [`ALU_CONTROL_SIZE-1:0] alu_control_i,
  input  logic [XLEN-1:0]              src_a_i,
  input  logic [XLEN-1:0]              src_b_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [XLEN-1:0]              result_o
);

  muldiv_state_e                state_q;
  logic                         busy_q;
  logic                         done_q;
  logic [XLEN-1:0]              result_q;
  logic [`ALU_CONTROL_SIZE-1:0] op_q;
  logic                         neg_quot_q;
  logic                         neg_rem_q;

  logic                         is_mul;
  logic                         quot_op;
  logic                         signed_div;
  logic                         a_neg;
  logic                         b_neg;
  logic [XLEN-1:0]              a_mag;
  logic [XLEN-1:0]              b_mag;
  logic                         div_by_zero;
  logic                         div_ovf;
  logic                         accept;
  logic                         div_load;
  logic                         div_step;
  logic                         div_last;
  logic [XLEN-1:0]              div_quot;
  logic [XLEN-1:0]              div_rem;
  logic [XLEN-1:0]              adj_result;

  logic                         a_sx;
  logic                         b_sx;
  logic [2*XLEN-1:0]            a_ext;
  logic [2*XLEN-1:0]            b_ext;
  logic [2*XLEN-1:0]            product;
  logic [XLEN-1:0]              mul_result;

  always_comb begin
    is_mul     = (alu_control_i == `ALU_MUL)    || (alu_control_i == `ALU_MULH) ||
                 (alu_control_i == `ALU_MULHSU) || (alu_control_i == `ALU_MULHU);
    quot_op    = (alu_control_i == `ALU_DIV)    || (alu_control_i == `ALU_DIVU);
    signed_div = (alu_control_i == `ALU_DIV)    || (alu_control_i == `ALU_REM);
  end

  // Sign-extending both operands to 64 bits gives the exact signed/mixed product modulo 2^64.
  always_comb begin
    a_sx       = ((alu_control_i == `ALU_MULH) || (alu_control_i == `ALU_MULHSU)) && src_a_i[XLEN-1];
    b_sx       = (alu_control_i == `ALU_MULH) && src_b_i[XLEN-1];
    a_ext      = {{XLEN{a_sx}}, src_a_i};
    b_ext      = {{XLEN{b_sx}}, src_b_i};
    product    = a_ext * b_ext;
    mul_result = (alu_control_i == `ALU_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
  end

  always_comb begin
    a_neg       = signed_div && src_a_i[XLEN-1];
    b_neg       = signed_div && src_b_i[XLEN-1];
    a_mag       = a_neg ? (~src_a_i + 1'b1) : src_a_i;
    b_mag       = b_neg ? (~src_b_i + 1'b1) : src_b_i;
    div_by_zero = (src_b_i == '0);
    div_ovf     = signed_div && (src_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (src_b_i == '1);
  end

  always_comb begin
    accept   = start_i && !flush_i && is_muldiv(alu_control_i) &&
               ((state_q == MD_IDLE) || (state_q == MD_DONE));
    div_load = accept && !is_mul && !div_by_zero && !div_ovf;
    div_step = (state_q == MD_DIV) && !flush_i;
  end

  div_iter #(
    .XLEN(XLEN)
  ) u_div_iter (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (div_load),
    .dividend_i  (a_mag),
    .divisor_i   (b_mag),
    .step_i      (div_step),
    .quotient_o  (div_quot),
    .remainder_o (div_rem),
    .last_o      (div_last)
  );

  always_comb begin
    adj_result = '0;
    if ((op_q == `ALU_DIV) || (op_q == `ALU_DIVU)) begin
      adj_result = neg_quot_q ? (~div_quot + 1'b1) : div_quot;
    end else begin
      adj_result = neg_rem_q ? (~div_rem + 1'b1) : div_rem;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= MD_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      op_q       <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else if (flush_i) begin
      state_q <= MD_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        MD_IDLE, MD_DONE: begin
          done_q  <= 1'b0;
          state_q <= MD_IDLE;
          if (accept) begin
            if (is_mul) begin
              result_q <= mul_result;
              done_q   <= 1'b1;
              state_q  <= MD_DONE;
            end else if (div_by_zero) begin
              result_q <= quot_op ? '1 : src_a_i;
              done_q   <= 1'b1;
              state_q  <= MD_DONE;
            end else if (div_ovf) begin
              result_q <= quot_op ? {1'b1, {(XLEN-1){1'b0}}} : '0;
              done_q   <= 1'b1;
              state_q  <= MD_DONE;
            end else begin
              op_q       <= alu_control_i;
              neg_quot_q <= a_neg ^ b_neg;
              neg_rem_q  <= a_neg;
              busy_q     <= 1'b1;
              state_q    <= MD_DIV;
            end
          end
        end
        MD_DIV: begin
          if (div_last) begin
            state_q <= MD_ADJ;
          end
        end
        MD_ADJ: begin
          result_q <= adj_result;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= MD_DONE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= MD_IDLE;
        end
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule
